led_share_arb: RTL and testbench
================================

Name: led_share_arb

Overview:
Round-robin arbiter and hold-timer that shares the 8-bit board LED bank between NREQ pattern requesters. A granted requester's pattern drives led_o for a programmable number of prescaled ticks. The block then releases the bank, shows the idle pattern and re-arbitrates. It sits between the status/debug sources and the top-level LED pins.

Parameters:
NREQ, 3, number of requesters (2..8)
PRESCALE, 16'h00ff, tick period is PRESCALE+1 clocks
DUR_W, 8, width of each per-requester duration field (in ticks)
IDLE_PAT, 8'hff, LED pattern shown at reset, in IDLE and in RELEASE

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req_i  in  NREQ  level request, one bit per requester
pat_i  in  8*NREQ  requester k pattern in bits [8k+7:8k]
dur_i  in  DUR_W*NREQ  requester k hold duration in ticks, bits [DUR_W*k+DUR_W-1:DUR_W*k]
gnt_o  in/out: out  NREQ  one-hot grant, high for the whole HOLD state
done_o  out  NREQ  one-cycle pulse on normal completion of requester k's hold
busy_o  out  1  high in HOLD and RELEASE
led_o  out  8  registered LED drive

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, led_o=IDLE_PAT, gnt_o=0, done_o=0, busy_o=0.
  - Prescaler=0, remaining=0, RR pointer=NREQ-1, so requester 0 wins first.
- All outputs are registered. State: 2-bit IDLE/HOLD/RELEASE.
- IDLE:
  - led_o=IDLE_PAT.
  - If req_i!=0, pick winner w = first set bit scanning ptr+1, ptr+2, ... modulo NREQ.
  - Same cycle: sample pat_i[w] and dur_i[w].
  - Next edge: state=HOLD, gnt_o[w]=1, led_o=pat_i[w], remaining=max(dur_i[w],1) (dur 0 treated as 1), prescaler=0, ptr=w.
- HOLD:
  - Prescaler increments each cycle. When prescaler==PRESCALE: prescaler<=0.
  - At that point, if remaining==1: go to RELEASE, gnt_o<=0, done_o[w]<=1 for one cycle, led_o<=IDLE_PAT. Otherwise remaining<=remaining-1.
  - HOLD therefore lasts exactly dur*(PRESCALE+1) cycles.
  - Pattern and duration are latched at grant; changes on pat_i/dur_i during HOLD are ignored.
- Abort: if req_i[w] drops during HOLD, the next edge goes to RELEASE with gnt_o=0, led_o=IDLE_PAT and no done_o pulse. Abort takes priority over a coincident final tick.
- RELEASE: exactly one cycle, led_o=IDLE_PAT, busy_o=1, then IDLE. No arbitration in RELEASE.
- Grant-to-grant spacing for back-to-back requests: dur*(PRESCALE+1)+2 cycles (one RELEASE plus one IDLE arbitration cycle).
- Fairness: the pointer advances only on grant. A requester that keeps req_i high is not re-granted while any other requester is pending.
- Requests asserted in HOLD/RELEASE wait; they are not latched. A request dropped before IDLE sampling is lost.
- Remaining counter is DUR_W bits and never wraps below 1.
- Prescaler is PRESCALE-width and wraps only at PRESCALE.
- Reset mid-HOLD: immediate return to reset values; no done_o.

Test Plan:
- Reset, no requests (PRESCALE=3) -> led_o=8'hff, gnt_o=0, busy_o=0 indefinitely.
- req_i=3'b001, pat0=8'h03, dur0=2 (PRESCALE=3):
  - gnt_o=001 one cycle after request; led_o=8'h03 for exactly 8 cycles.
  - done_o=001 pulse; led_o=8'hff one cycle, then regrant after one IDLE cycle.
- req_i=3'b111 held, pats 8'h03/8'h3c/8'hc0, all dur=1 (PRESCALE=3) -> grant order 0,1,2,0; each led_o pattern lasts 4 cycles; grants 6 cycles apart.
- Requester 1 granted with dur=5; drop req_i[1] after 3 cycles of HOLD -> next edge RELEASE, gnt_o=0, led_o=8'hff, done_o stays 0.
- dur0=0 -> treated as 1 tick (PRESCALE+1 cycles of pattern).
- Change pat_i during HOLD -> led_o unchanged.
- Assert rst_n low mid-HOLD -> same cycle led_o=8'hff, gnt_o=0. After release, req0 wins first.

Source files
------------

// File: rtl/led_share_arb.sv
// led_share_arb: round-robin arbiter sharing the 8-bit LED bank between NREQ pattern requesters
// Ports: clk, rst_n (async active-low); req_i level requests; pat_i/dur_i per-requester pattern
// and hold duration in ticks; gnt_o one-hot grant during HOLD; done_o completion pulse;
// busy_o high in HOLD/RELEASE; led_o registered LED drive.
module led_share_arb #(
  parameter int NREQ = 3,
  parameter logic [15:0] PRESCALE = 16'h00ff,
  parameter int DUR_W = 8,
  parameter logic [7:0] IDLE_PAT = 8'hff
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_i,
  input  logic [8*NREQ-1:0]       pat_i,
  input  logic [DUR_W*NREQ-1:0]   dur_i,
  output logic [NREQ-1:0]         gnt_o,
  output logic [NREQ-1:0]         done_o,
  output logic                    busy_o,
  output logic [7:0]              led_o
);
  typedef enum logic [1:0] {IDLE, HOLD, RELEASE} state_t;
  state_t state, state_nx;
  logic [15:0] pre;
  logic [DUR_W-1:0] rem, dur_sel;
  logic [NREQ-1:0] ptr, hi_mask, masked, win;
  logic [7:0] pat_sel;
  logic tick, fin, abort;
  // ptr is one-hot; requesters above it get first pick, otherwise wrap to the lowest set bit
  assign hi_mask = ~((ptr << 1) - NREQ'(1));
  assign masked = req_i & hi_mask;
  assign win = |masked ? masked & -masked : req_i & -req_i;
  assign tick = pre == PRESCALE;
  assign fin = tick && rem == DUR_W'(1);
  assign abort = ~|(req_i & gnt_o);
  always_comb begin
    pat_sel = '0;
    dur_sel = '0;
    for (int k = 0; k < NREQ; k++) begin
      pat_sel |= pat_i[8*k +: 8] & {8{win[k]}};
      dur_sel |= dur_i[DUR_W*k +: DUR_W] & {DUR_W{win[k]}};
    end
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (|req_i) state_nx = HOLD;
      HOLD:    if (abort || fin) state_nx = RELEASE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_o  <= IDLE_PAT;
      gnt_o  <= '0;
      done_o <= '0;
      busy_o <= 1'b0;
      pre    <= '0;
      rem    <= '0;
      ptr    <= {1'b1, {(NREQ-1){1'b0}}};
    end else begin
      done_o <= '0;
      case (state)
        IDLE: begin
          led_o <= IDLE_PAT;
          busy_o <= 1'b0;
          if (|req_i) begin
            gnt_o  <= win;
            ptr    <= win;
            led_o  <= pat_sel;
            rem    <= |dur_sel ? dur_sel : DUR_W'(1);
            pre    <= '0;
            busy_o <= 1'b1;
          end
        end
        HOLD: begin
          if (abort || fin) begin
            gnt_o  <= '0;
            led_o  <= IDLE_PAT;
            pre    <= '0;
            // a dropped request suppresses done even on the final tick
            done_o <= abort ? '0 : gnt_o;
          end else begin
            pre <= tick ? '0 : pre + 16'd1;
            rem <= tick ? rem - DUR_W'(1) : rem;
          end
        end
        default: begin
          led_o  <= IDLE_PAT;
          busy_o <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_led_share_arb.sv
// tb_led_share_arb: randomized self-checking bench against a cycle-count reference model
module tb_led_share_arb;
  localparam int N = 3;
  localparam int P = 3;
  localparam int DW = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic [8*N-1:0] pat = '0;
  logic [DW*N-1:0] dur = '0;
  logic [N-1:0] gnt, done;
  logic busy;
  logic [7:0] led;
  int n_chk = 0;
  int n_err = 0;
  int m_phase, m_w, m_left, m_ptr;
  logic [7:0] e_led;
  logic [N-1:0] e_gnt, e_done;
  logic e_busy;
  led_share_arb #(.NREQ(N), .PRESCALE(16'd3), .DUR_W(DW), .IDLE_PAT(8'hff)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .pat_i(pat), .dur_i(dur),
    .gnt_o(gnt), .done_o(done), .busy_o(busy), .led_o(led)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask
  function automatic int dur_of(input int k);
    return int'((dur >> (DW*k)) & 24'hff);
  endfunction
  task automatic model_reset();
    m_phase = 0;
    m_w = 0;
    m_left = 0;
    m_ptr = N-1;
    e_led = 8'hff;
    e_gnt = '0;
    e_done = '0;
    e_busy = 1'b0;
  endtask
  // phase 0 idle, 1 hold (m_left counts clock cycles left), 2 release
  task automatic model_step();
    e_done = '0;
    if (m_phase == 0) begin
      if (req != 0) begin
        for (int i = 1; i <= N; i++) begin
          int k;
          k = (m_ptr + i) % N;
          if (req[k] && m_phase == 0) begin
            m_w = k;
            m_phase = 1;
          end
        end
        m_left = (dur_of(m_w) == 0 ? 1 : dur_of(m_w)) * (P + 1);
        e_gnt = N'(1) << m_w;
        e_led = 8'(pat >> (8*m_w));
        m_ptr = m_w;
        e_busy = 1'b1;
      end
    end else if (m_phase == 1) begin
      if (!req[m_w]) begin
        m_phase = 2;
        e_gnt = '0;
        e_led = 8'hff;
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_phase = 2;
          e_gnt = '0;
          e_done = N'(1) << m_w;
          e_led = 8'hff;
        end
      end
    end else begin
      m_phase = 0;
      e_busy = 1'b0;
    end
  endtask
  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("led", 32'(led), 32'(e_led));
    check("gnt", 32'(gnt), 32'(e_gnt));
    check("done", 32'(done), 32'(e_done));
    check("busy", 32'(busy), 32'(e_busy));
  endtask
  // called at a negedge; reset takes effect immediately, released at the next negedge
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_led", 32'(led), 32'hff);
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    model_reset();
    @(negedge clk);
    do_reset();
    req = '0;
    repeat (8) step();
    pat[7:0] = 8'h03;
    dur[7:0] = 8'd2;
    req = 3'b001;
    repeat (20) step();
    req = '0;
    repeat (3) step();
    pat = 24'hc03c03;
    dur = 24'h010101;
    req = 3'b111;
    repeat (26) step();
    req = '0;
    repeat (3) step();
    do_reset();
    pat = 24'h003c00;
    dur = 24'h000500;
    req = 3'b010;
    step();
    repeat (3) step();
    req = '0;
    repeat (4) step();
    dur = '0;
    pat = 24'h00005a;
    req = 3'b001;
    repeat (12) begin
      step();
      pat = 24'($urandom);
    end
    req = '0;
    repeat (6) step();
    dur = 24'h000003;
    req = 3'b001;
    repeat (4) step();
    do_reset();
    dur = 24'h010101;
    req = 3'b111;
    repeat (8) step();
    repeat (3000) begin
      if ($urandom_range(0, 11) == 0) req ^= N'(1) << $urandom_range(0, N-1);
      pat = 24'($urandom);
      dur = {8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)), 8'($urandom_range(0, 3))};
      if ($urandom_range(0, 599) == 0) do_reset();
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
